// File: rtl/gpc_pkg.sv
// ---------------------------------------------------------------------------
// gpc_pkg
// Shared definitions for the GPC231_4 family of blocks.
//   - state_t      : FSM state encoding used by gpc231_4_accum
//   - GPC_* consts : shape of a (2,3,1;4) generalised parallel counter.
//                    Column weights {1,2,4}, input bit counts {1,3,2},
//                    a 4-bit result and a largest result of 15.
// ---------------------------------------------------------------------------
package gpc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int GPC_N_COLS = 3;
  // Element [i] belongs to column i (LSB column first).
  localparam logic [GPC_N_COLS-1:0][3:0] GPC_WEIGHTS = {4'd4, 4'd2, 4'd1};
  localparam logic [GPC_N_COLS-1:0][3:0] GPC_COUNTS  = {4'd2, 4'd3, 4'd1};
  localparam int GPC_OUT_W = 4;
  localparam int GPC_MAX   = 15;

  // Largest value a GPC with the given column shape can produce
  // (sum over columns of weight * number of input bits).
  function automatic int gpc_max_value(
    input logic [GPC_N_COLS-1:0][3:0] weights,
    input logic [GPC_N_COLS-1:0][3:0] counts
  );
    int total;
    total = 0;
    for (int i = 0; i < GPC_N_COLS; i++) begin
      total = total + int'(weights[i]) * int'(counts[i]);
    end
    return total;
  endfunction

endpackage

// File: rtl/gpc231_4_accum.sv
// ---------------------------------------------------------------------------
// gpc231_4_accum
// Sums N_SAMPLES consecutive gpc231_4 results into an ACC_W-bit accumulator
// and presents the total with a valid/ready handshake.
//
// Ports
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   start     : one-cycle pulse, begins a run (honoured in IDLE only)
//   abort     : cancels the run in progress (ACC or HOLD), result dropped
//   in_valid  : upstream presents a gpc231_4 dst value
//   in_dst    : gpc231_4 dst value, 0..15
//   in_ready  : accepting in_dst this cycle (registered, ACC only)
//   out_valid : result available (HOLD)
//   out_ready : downstream accepts the result
//   out_sum   : accumulated sum modulo 2^ACC_W
//   out_ovf   : sticky, some addition of the run carried out of ACC_W bits
//   busy      : FSM is not in IDLE
// ---------------------------------------------------------------------------
module gpc231_4_accum
  import gpc_pkg::*;
#(
  parameter int N_SAMPLES = 16,
  parameter int ACC_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 in_valid,
  input  logic [GPC_OUT_W-1:0] in_dst,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_sum,
  output logic                 out_ovf,
  output logic                 busy
);

  // Wide enough to hold N_SAMPLES itself, so the counter never wraps.
  localparam int CNT_W = $clog2(N_SAMPLES + 1);
  localparam int SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;

  logic             beat;
  logic             last_beat;
  logic [SUM_W-1:0] sum_ext;

  // Transfer qualification and the widened adder; the extra MSB is the carry.
  always_comb begin
    beat      = in_valid & in_ready;
    last_beat = beat & (count == LAST_IDX);
    sum_ext   = {1'b0, acc} + SUM_W'(in_dst);
  end

  // Run-control FSM with its datapath registers and registered outputs.
  // abort is tested before the beat in ACC so that it wins over a final beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // start together with abort keeps the block idle
          if (start && !abort) begin
            acc      <= '0;
            count    <= '0;
            out_ovf  <= 1'b0;
            state    <= ACC;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end

        ACC: begin
          if (abort) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end else if (beat) begin
            acc     <= sum_ext[ACC_W-1:0];
            count   <= count + CNT_W'(1);
            out_sum <= sum_ext[ACC_W-1:0];
            out_ovf <= out_ovf | sum_ext[ACC_W];
            if (last_beat) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end

        HOLD: begin
          // abort and a completed handshake both return to IDLE
          if (abort || out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpc231_4_accum.sv
// ---------------------------------------------------------------------------
// tb_gpc231_4_accum
// Self-checking bench: one default instance (ACC_W=8) and one ACC_W=6
// instance sharing all inputs. Table-driven runs use a scoreboard queue;
// hand-written sequences cover abort, start-while-busy and reset corners.
// ---------------------------------------------------------------------------
module tb_gpc231_4_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       in_valid;
  logic [3:0] in_dst;
  logic       out_ready;

  logic       in_ready,  out_valid,  out_ovf,  busy;
  logic [7:0] out_sum;
  logic       in_ready6, out_valid6, out_ovf6, busy6;
  logic [5:0] out_sum6;

  always #5 clk = ~clk;

  gpc231_4_accum #(.N_SAMPLES(16), .ACC_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_dst(in_dst), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .busy(busy)
  );

  gpc231_4_accum #(.N_SAMPLES(16), .ACC_W(6)) dut6 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_dst(in_dst), .in_ready(in_ready6),
    .out_valid(out_valid6), .out_ready(out_ready),
    .out_sum(out_sum6), .out_ovf(out_ovf6), .busy(busy6)
  );

  // val < 0 means a ramp: beat i carries i mod 16
  typedef struct {
    int val;
    int gap_max;
    int hold_cycles;
    int exp_sum8;
    bit exp_ovf8;
    int exp_sum6;
    bit exp_ovf6;
  } vec_t;

  typedef struct {
    logic [7:0] s8;
    logic       o8;
    logic [5:0] s6;
    logic       o6;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_beats(input int n, input int val, input int gap_max);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_dst   = (val < 0) ? 4'(i) : 4'(val);
      tick();
      in_valid = 1'b0;
      if (i != n - 1) begin
        int g;
        g = int'($urandom_range(0, gap_max));
        repeat (g) tick();
      end
    end
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_in_ready", in_ready, 1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    sb.push_back('{8'(v.exp_sum8), v.exp_ovf8, 6'(v.exp_sum6), v.exp_ovf6});
    start_run();
    drive_beats(16, v.val, v.gap_max);
    chk($sformatf("v%0d_latency_valid", idx), out_valid, 1);
    chk($sformatf("v%0d_latency_valid6", idx), out_valid6, 1);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL v%0d_scoreboard: got empty queue expected one entry", idx);
    end else begin
      e = sb.pop_front();
      chk($sformatf("v%0d_sum8", idx), out_sum, e.s8);
      chk($sformatf("v%0d_ovf8", idx), out_ovf, e.o8);
      chk($sformatf("v%0d_sum6", idx), out_sum6, e.s6);
      chk($sformatf("v%0d_ovf6", idx), out_ovf6, e.o6);
      out_ready = 1'b0;
      repeat (v.hold_cycles) begin
        tick();
        chk($sformatf("v%0d_hold_valid", idx), out_valid, 1);
        chk($sformatf("v%0d_hold_sum", idx), out_sum, e.s8);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk($sformatf("v%0d_done_busy", idx), busy, 0);
      chk($sformatf("v%0d_done_valid", idx), out_valid, 0);
      chk($sformatf("v%0d_idle_sum_kept", idx), out_sum, e.s8);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{2,   1, 0,  32, 1'b0, 32, 1'b0};
    vecs[1] = '{15,  0, 5, 240, 1'b0, 48, 1'b1};
    vecs[2] = '{1,   3, 1,  16, 1'b0, 16, 1'b0};
    vecs[3] = '{-1,  0, 0, 120, 1'b0, 56, 1'b1};
    vecs[4] = '{0,   2, 0,   0, 1'b0,  0, 1'b0};
    vecs[5] = '{9,   1, 2, 144, 1'b0, 16, 1'b1};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_dst = 4'd0; out_ready = 1'b0;
    tick();
    chk("rst_sum", out_sum, 0);
    chk("rst_ovf", out_ovf, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum6", out_sum6, 0);
    rst = 1'b0;
    tick();

    // abort after 7 beats: back to IDLE with no result
    start_run();
    drive_beats(7, 3, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort7_busy", busy, 0);
    chk("abort7_in_ready", in_ready, 0);
    chk("abort7_valid", out_valid, 0);
    repeat (3) tick();
    chk("abort7_valid_later", out_valid, 0);

    // table runs (first one is the fresh run of 2s after the abort)
    for (int i = 0; i < 6; i++) begin
      run_vec(i, vecs[i]);
      tick();
    end

    // abort together with the final beat: beat dropped, no result
    start_run();
    drive_beats(15, 1, 0);
    in_valid = 1'b1; in_dst = 4'd1; abort = 1'b1;
    tick();
    in_valid = 1'b0; abort = 1'b0;
    chk("abort_last_valid", out_valid, 0);
    chk("abort_last_busy", busy, 0);
    tick();
    chk("abort_last_valid_later", out_valid, 0);

    // start in ACC is ignored; the run continues unchanged
    start_run();
    drive_beats(4, 1, 0);
    start = 1'b1; in_valid = 1'b1; in_dst = 4'd1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    drive_beats(11, 1, 0);
    chk("start_in_acc_valid", out_valid, 1);
    chk("start_in_acc_sum", out_sum, 16);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // start in HOLD ignored, then abort in HOLD drops the result
    start_run();
    drive_beats(16, 4, 0);
    chk("hold_sum", out_sum, 64);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_hold_valid", out_valid, 1);
    chk("start_in_hold_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_hold_valid", out_valid, 0);
    chk("abort_hold_busy", busy, 0);

    // start and abort together in IDLE stay idle
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_in_ready", in_ready, 0);

    // reset after the 10th beat clears everything immediately
    start_run();
    drive_beats(10, 5, 0);
    chk("pre_rst_sum", out_sum, 50);
    #1 rst = 1'b1;
    #1;
    chk("midrst_sum", out_sum, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ovf", out_ovf, 0);
    tick();
    rst = 1'b0;
    in_valid = 1'b1; in_dst = 4'd5;
    repeat (5) begin
      tick();
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_busy", busy, 0);
    end
    in_valid = 1'b0;

    // recovery: a full run after reset
    run_vec(6, vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
